// File: rtl/core_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// core_mem_arbiter_pkg
// Shared constants for the core memory arbiter: per-core enable codes and
// default memory geometry, plus a request-decode helper.
// -----------------------------------------------------------------------------
package core_mem_arbiter_pkg;

    // Per-core enable bus codes (2'b11 is reserved and never granted)
    localparam logic [1:0] EN_IDLE  = 2'b00;
    localparam logic [1:0] EN_READ  = 2'b01;
    localparam logic [1:0] EN_WRITE = 2'b10;

    // Default geometry
    localparam int unsigned DEFAULT_CORE_COUNT = 4;
    localparam int unsigned MEM_WIDTH          = 8;   // default REG_SIZE
    localparam int unsigned MEM_ADDR_W         = 8;   // default ADDR_SIZE

    // True only for the two legal request codes
    function automatic logic is_request(input logic [1:0] en);
        logic r;
        r = 1'b0;
        case (en)
            EN_READ, EN_WRITE: r = 1'b1;
            EN_IDLE:           r = 1'b0;
            default:           r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/core_mem_arbiter_picker.sv
// -----------------------------------------------------------------------------
// mem_arb_picker
// Combinational grant selection for core_mem_arbiter.
//   MEM_ARB_ROUND_ROBIN_EN defined  : first requester at or after ptr, cyclic.
//   MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins; no
//                                     ptr port.
// Ports:
//   req   in  CORE_COUNT : request vector, bit i for core i
//   ptr   in  PTR_W      : round-robin start index (round-robin build only)
//   grant out CORE_COUNT : one-hot grant (all zero when no request)
//   valid out 1          : at least one request present
// -----------------------------------------------------------------------------
module mem_arb_picker #(
    parameter int unsigned CORE_COUNT = 4,
    parameter int unsigned PTR_W      = $clog2(CORE_COUNT)
) (
    input  logic [CORE_COUNT-1:0] req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic [PTR_W-1:0]      ptr,
`endif
    output logic [CORE_COUNT-1:0] grant,
    output logic                  valid
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Walk CORE_COUNT positions starting at ptr; one extra bit holds the
    // unwrapped sum so the wrap works for non-power-of-two core counts.
    logic [PTR_W:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned off = 0; off < CORE_COUNT; off++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(off);
            if (idx >= (PTR_W+1)'(CORE_COUNT))
                idx = idx - (PTR_W+1)'(CORE_COUNT);
            if (!valid && req[idx[PTR_W-1:0]]) begin
                grant[idx[PTR_W-1:0]] = 1'b1;
                valid                 = 1'b1;
            end
        end
    end
`else
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < CORE_COUNT; i++) begin
            if (!valid && req[PTR_W'(i)]) begin
                grant[PTR_W'(i)] = 1'b1;
                valid            = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/core_mem_arbiter.sv
// -----------------------------------------------------------------------------
// core_mem_arbiter
// Arbitrates read/write requests from CORE_COUNT cores onto one internal
// single-ported data memory, one access at a time (IDLE -> ACCESS -> DONE).
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// otherwise fixed priority (lowest index wins).
// Ports:
//   clk          in  1                    : rising-edge clock
//   reset        in  1                    : asynchronous, active-low
//   core_enable  in  CORE_COUNT*2         : per-core op, 00 idle/01 rd/10 wr
//   core_addr    in  CORE_COUNT*ADDR_SIZE : per-core word address
//   core_wr_data in  CORE_COUNT*REG_SIZE  : per-core write data
//   rd_data      out REG_SIZE             : read data, valid with ready_sig
//   ready_sig    out CORE_COUNT           : one-hot completion pulse
// -----------------------------------------------------------------------------
module core_mem_arbiter
    import core_mem_arbiter_pkg::*;
#(
    parameter int unsigned CORE_COUNT = DEFAULT_CORE_COUNT,
    parameter int unsigned REG_SIZE   = MEM_WIDTH,
    parameter int unsigned ADDR_SIZE  = MEM_ADDR_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [CORE_COUNT*2-1:0]         core_enable,
    input  logic [CORE_COUNT*ADDR_SIZE-1:0] core_addr,
    input  logic [CORE_COUNT*REG_SIZE-1:0]  core_wr_data,
    output logic [REG_SIZE-1:0]             rd_data,
    output logic [CORE_COUNT-1:0]           ready_sig
);

    localparam int unsigned PTR_W = $clog2(CORE_COUNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e                 state;
    logic [PTR_W-1:0]       win_idx;
    logic                   op_wr;
    logic [ADDR_SIZE-1:0]   lat_addr;
    logic [REG_SIZE-1:0]    lat_data;

    logic [REG_SIZE-1:0]    mem [2**ADDR_SIZE];

    logic [CORE_COUNT-1:0]  req;
    logic [CORE_COUNT-1:0]  grant;
    logic                   grant_valid;

    logic [PTR_W-1:0]       sel_idx;
    logic [1:0]             sel_en;
    logic [ADDR_SIZE-1:0]   sel_addr;
    logic [REG_SIZE-1:0]    sel_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0]       ptr;
`endif

    // Request decode: reserved code 2'b11 never becomes a request
    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < CORE_COUNT; i++)
            req[PTR_W'(i)] = is_request(core_enable[2*i +: 2]);
    end

    mem_arb_picker #(
        .CORE_COUNT (CORE_COUNT),
        .PTR_W      (PTR_W)
    ) u_picker (
        .req   (req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .ptr   (ptr),
`endif
        .grant (grant),
        .valid (grant_valid)
    );

    // One-hot grant -> index and the winner's request fields
    always_comb begin
        sel_idx  = '0;
        sel_en   = EN_IDLE;
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < CORE_COUNT; i++) begin
            if (grant[PTR_W'(i)]) begin
                sel_idx  = PTR_W'(i);
                sel_en   = core_enable[2*i +: 2];
                sel_addr = core_addr[i*ADDR_SIZE +: ADDR_SIZE];
                sel_data = core_wr_data[i*REG_SIZE +: REG_SIZE];
            end
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ready_sig <= '0;
            rd_data   <= '0;
            win_idx   <= '0;
            op_wr     <= 1'b0;
            lat_addr  <= '0;
            lat_data  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr       <= '0;
`endif
        end else begin
            ready_sig <= '0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        win_idx  <= sel_idx;
                        op_wr    <= (sel_en == EN_WRITE);
                        lat_addr <= sel_addr;
                        lat_data <= sel_data;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!op_wr)
                        rd_data <= mem[lat_addr];
                    // Set on the ACCESS->DONE edge so the pulse covers DONE
                    ready_sig <= {{(CORE_COUNT-1){1'b0}}, 1'b1} << win_idx;
                    state     <= DONE;
                end
                DONE: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    if (win_idx == PTR_W'(CORE_COUNT-1))
                        ptr <= '0;
                    else
                        ptr <= win_idx + PTR_W'(1);
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory write port; contents are not reset. An asynchronous reset
    // during ACCESS forces state to IDLE before the edge, so no commit.
    always_ff @(posedge clk) begin
        if (reset && state == ACCESS && op_wr)
            mem[lat_addr] <= lat_data;
    end

endmodule
